// File: rtl/drac_wb_master_if.sv
// Bundles the DRAC line-request port and the 32-bit Wishbone master port.
// The master modport is the bridge's view; the slave modport is its environment.
interface drac_wb_master_if;
  logic         drac_srd_i;
  logic         drac_swr_i;
  logic [33:5]  drac_sa_i;
  logic [255:0] drac_swdat_i;
  logic [31:0]  drac_smsk_i;
  logic [255:0] drac_srdat_o;
  logic         drac_srdy_o;
  logic         drac_serr_o;
  logic [35:0]  wb_adr_o;
  logic         wb_we_o;
  logic [3:0]   wb_sel_o;
  logic         wb_stb_o;
  logic         wb_cyc_o;
  logic [31:0]  wb_dat_o;
  logic [31:0]  wb_dat_i;
  logic         wb_ack_i;
  logic         wb_err_i;

  modport master (
    input  drac_srd_i, drac_swr_i, drac_sa_i, drac_swdat_i, drac_smsk_i,
    output drac_srdat_o, drac_srdy_o, drac_serr_o,
    output wb_adr_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output drac_srd_i, drac_swr_i, drac_sa_i, drac_swdat_i, drac_smsk_i,
    input  drac_srdat_o, drac_srdy_o, drac_serr_o,
    input  wb_adr_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/drac_wb_master.sv
// Turns one 256-bit DRAC line read/write into a burst of up to eight classic
// 32-bit Wishbone beats under a single cycle; fully masked write words are skipped.
module drac_wb_master #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  drac_wb_master_if.master bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t         state_reg, state_next;
  logic [33:5]    sa_reg, sa_next;
  logic           we_reg, we_next;
  logic [255:0]   wdat_reg, wdat_next;
  logic [31:0]    msk_reg, msk_next;
  logic [7:0]     pend_reg, pend_next;
  logic [2:0]     beat_reg, beat_next;
  logic [TW-1:0]  tmo_reg, tmo_next;
  logic           err_reg, err_next;
  logic [255:0]   srdat_reg, srdat_next;

  logic [35:0]    adr_reg, adr_next;
  logic           wbwe_reg, wbwe_next;
  logic [3:0]     sel_reg, sel_next;
  logic           stb_reg, stb_next;
  logic [31:0]    dat_reg, dat_next;
  logic           srdy_reg, srdy_next;
  logic           serr_reg, serr_next;

  logic [7:0]     req_pend_wr;
  logic [31:0]    wdat_word [8];
  logic [3:0]     msk_nib [8];
  logic           timed_out, beat_fail, beat_end;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_word
      assign req_pend_wr[gi] = ~&bus.drac_smsk_i[4*gi +: 4];
      assign wdat_word[gi]   = wdat_next[32*gi +: 32];
      assign msk_nib[gi]     = msk_next[4*gi +: 4];
    end
  endgenerate

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  // Error wins over ack, and a simultaneous timeout also counts as a failure.
  assign timed_out = (TIMEOUT != 0) && (tmo_reg == TMO_MAX);
  assign beat_fail = bus.wb_err_i || timed_out;
  assign beat_end  = bus.wb_ack_i || beat_fail;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      we_reg    <= 1'b0;
      wdat_reg  <= '0;
      msk_reg   <= '0;
      pend_reg  <= '0;
      beat_reg  <= '0;
      tmo_reg   <= '0;
      err_reg   <= 1'b0;
      srdat_reg <= '0;
      adr_reg   <= '0;
      wbwe_reg  <= 1'b0;
      sel_reg   <= '0;
      stb_reg   <= 1'b0;
      dat_reg   <= '0;
      srdy_reg  <= 1'b0;
      serr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sa_reg    <= sa_next;
      we_reg    <= we_next;
      wdat_reg  <= wdat_next;
      msk_reg   <= msk_next;
      pend_reg  <= pend_next;
      beat_reg  <= beat_next;
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
      srdat_reg <= srdat_next;
      adr_reg   <= adr_next;
      wbwe_reg  <= wbwe_next;
      sel_reg   <= sel_next;
      stb_reg   <= stb_next;
      dat_reg   <= dat_next;
      srdy_reg  <= srdy_next;
      serr_reg  <= serr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sa_next    = sa_reg;
    we_next    = we_reg;
    wdat_next  = wdat_reg;
    msk_next   = msk_reg;
    pend_next  = pend_reg;
    beat_next  = beat_reg;
    tmo_next   = tmo_reg;
    err_next   = err_reg;
    srdat_next = srdat_reg;
    case (state_reg)
      IDLE: begin
        if (bus.drac_srd_i || bus.drac_swr_i) begin
          sa_next    = bus.drac_sa_i;
          we_next    = bus.drac_swr_i;
          wdat_next  = bus.drac_swdat_i;
          msk_next   = bus.drac_smsk_i;
          pend_next  = bus.drac_swr_i ? req_pend_wr : 8'hFF;
          err_next   = 1'b0;
          tmo_next   = '0;
          beat_next  = lowest_set(pend_next);
          state_next = (pend_next == 8'h00) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (beat_end) begin
          if (!we_reg)
            srdat_next[32*beat_reg +: 32] = beat_fail ? 32'hFFFF_FFFF : bus.wb_dat_i;
          if (beat_fail)
            err_next = 1'b1;
          pend_next = pend_reg & ~(8'b1 << beat_reg);
          beat_next = lowest_set(pend_next);
          tmo_next  = '0;
          if (pend_next == 8'h00)
            state_next = DONE;
        end else if (TIMEOUT != 0) begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wishbone outputs are registered from the next-cycle beat so they hold still while waiting.
  always_comb begin
    adr_next  = {4'b0, sa_next, beat_next};
    wbwe_next = we_next;
    sel_next  = we_next ? ~msk_nib[beat_next] : 4'hF;
    dat_next  = wdat_word[beat_next];
    stb_next  = (state_next == ISSUE);
    srdy_next = (state_next == DONE);
    serr_next = (state_next == DONE) && err_next;
  end

  assign bus.wb_adr_o     = adr_reg;
  assign bus.wb_we_o      = wbwe_reg;
  assign bus.wb_sel_o     = sel_reg;
  assign bus.wb_stb_o     = stb_reg;
  assign bus.wb_cyc_o     = stb_reg;
  assign bus.wb_dat_o     = dat_reg;
  assign bus.drac_srdat_o = srdat_reg;
  assign bus.drac_srdy_o  = srdy_reg;
  assign bus.drac_serr_o  = serr_reg;

endmodule

// File: tb/tb_drac_wb_master.sv
// Self-checking bench for drac_wb_master: directed vector table, reset-mid-burst
// sequence and randomized requests against a beat-list reference model.
module tb_drac_wb_master;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  drac_wb_master_if bus();

  drac_wb_master #(.TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- slave model ----------------
  int          slv_waits = 0;
  int          slv_err_beat = -1;
  int          slv_silent_beat = -1;
  logic        slv_ack_on_err = 1'b0;
  logic [31:0] slv_mem [8];
  logic [35:0] prev_adr = '0;
  int          wcnt = 0;
  int          wait_now;
  logic [2:0]  s_beat;
  logic        s_resp;

  assign s_beat   = bus.wb_adr_o[2:0];
  assign wait_now = (bus.wb_adr_o == prev_adr) ? wcnt : 0;
  assign s_resp   = bus.wb_cyc_o && bus.wb_stb_o && (int'(s_beat) != slv_silent_beat)
                    && (wait_now >= slv_waits);
  assign bus.wb_err_i = s_resp && (int'(s_beat) == slv_err_beat);
  assign bus.wb_ack_i = s_resp && ((int'(s_beat) != slv_err_beat) || slv_ack_on_err);
  assign bus.wb_dat_i = slv_mem[s_beat];

  always @(posedge clk) begin
    prev_adr <= bus.wb_adr_o;
    if (bus.wb_stb_o && !(bus.wb_ack_i || bus.wb_err_i)) wcnt <= wait_now + 1;
    else wcnt <= 0;
  end

  // ---------------- bus monitor ----------------
  typedef struct packed {
    logic [35:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  beat_t mon_cur, mon_prev;
  logic  mon_prev_stb = 1'b0;
  int    stab_viol = 0;
  int    cycstb_viol = 0;
  int    cyc_high = 0;

  assign mon_cur = {bus.wb_adr_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_dat_o};

  always @(negedge clk) begin
    if (bus.wb_cyc_o !== bus.wb_stb_o) cycstb_viol <= cycstb_viol + 1;
    if (bus.wb_stb_o) begin
      cyc_high <= cyc_high + 1;
      if (mon_prev_stb && mon_cur.adr == mon_prev.adr) begin
        if (mon_cur !== mon_prev) stab_viol <= stab_viol + 1;
      end else begin
        obs_q.push_back(mon_cur);
      end
    end
    mon_prev_stb <= bus.wb_stb_o;
    mon_prev     <= mon_cur;
  end

  // ---------------- reference model ----------------
  logic [255:0] exp_srdat = '0;

  task automatic model_txn(input logic we, input logic [33:5] sa, input logic [255:0] wdat,
                           input logic [31:0] msk, output int lat, output logic serr);
    lat  = 1;
    serr = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      logic [3:0] nib;
      logic       silent, bad;
      beat_t      b;
      nib = msk[4*k +: 4];
      if (we && nib == 4'hF) continue;
      silent = (k == slv_silent_beat);
      bad    = silent || (k == slv_err_beat);
      b.adr  = {4'b0, sa, 3'(k)};
      b.we   = we;
      b.sel  = we ? ~nib : 4'hF;
      b.dat  = wdat[32*k +: 32];
      exp_q.push_back(b);
      lat += silent ? (TO + 1) : (slv_waits + 1);
      if (bad) serr = 1'b1;
      if (!we) exp_srdat[32*k +: 32] = bad ? 32'hFFFF_FFFF : slv_mem[k];
    end
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic we, input logic both,
                         input logic [33:5] sa, input logic [255:0] wdat, input logic [31:0] msk,
                         input int t_lat, input int t_serr, input int t_nb);
    int   m_lat, lat, t0, cyc0, nb;
    logic m_serr, serr, got;
    model_txn(we, sa, wdat, msk, m_lat, m_serr);
    @(negedge clk);
    obs_q.delete();
    cyc0 = cyc_high;
    bus.drac_srd_i   = !we || both;
    bus.drac_swr_i   = we;
    bus.drac_sa_i    = sa;
    bus.drac_swdat_i = wdat;
    bus.drac_smsk_i  = msk;
    t0  = cyc_cnt;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.drac_srdy_o) begin
        got = 1'b1;
        break;
      end
    end
    lat  = cyc_cnt - t0;
    serr = bus.drac_serr_o;
    chk({tag, "_srdy_seen"}, 256'(got), 256'(1));
    chk({tag, "_latency"}, 256'(lat), 256'(m_lat));
    if (t_lat >= 0) chk({tag, "_tbl_latency"}, 256'(lat), 256'(t_lat));
    chk({tag, "_serr"}, 256'(serr), 256'(m_serr));
    if (t_serr >= 0) chk({tag, "_tbl_serr"}, 256'(serr), 256'(t_serr));
    chk({tag, "_srdat"}, bus.drac_srdat_o, exp_srdat);
    chk({tag, "_cyc_cycles"}, 256'(cyc_high - cyc0), 256'(m_lat - 1));
    nb = obs_q.size();
    chk({tag, "_nbeats"}, 256'(nb), 256'(exp_q.size()));
    if (t_nb >= 0) chk({tag, "_tbl_nbeats"}, 256'(nb), 256'(t_nb));
    for (int i = 0; i < nb && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 256'(obs_q[i]), 256'(exp_q[i]));
    bus.drac_srd_i = 1'b0;
    bus.drac_swr_i = 1'b0;
    $display("txn %s we=%0d sa=%h lat=%0d serr=%0d beats=%0d", tag, we, sa, lat, serr, nb);
    @(negedge clk);
    chk({tag, "_srdy_pulse"}, 256'(bus.drac_srdy_o), 256'(0));
  endtask

  typedef struct {
    logic         we;
    logic [33:5]  sa;
    logic [255:0] wdat;
    logic [31:0]  msk;
    int           waits;
    int           err_beat;
    int           silent;
    int           exp_lat;
    int           exp_serr;
    int           exp_nb;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [255:0] w_sparse, w_full, w_any;
    logic [255:0] line;
    logic [31:0]  m;
    logic         found;

    bus.drac_srd_i   = 1'b0;
    bus.drac_swr_i   = 1'b0;
    bus.drac_sa_i    = '0;
    bus.drac_swdat_i = '0;
    bus.drac_smsk_i  = '0;
    for (int k = 0; k < 8; k++) slv_mem[k] = 32'hA0 + 32'(k);

    w_sparse = {8{32'h5555_5555}};
    w_sparse[31:0]    = 32'h1111_1111;
    w_sparse[255:224] = 32'h7777_7777;
    w_full = '0;
    for (int k = 0; k < 8; k++) w_full[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
    w_any = {8{32'hDEAD_BEEF}};

    //          we    sa           wdat      msk            wt er sil lat serr nb
    tbl[0] = '{1'b0, 29'h1000,    w_any,    32'h0,         0, -1, -1,  9, 0, 8};
    tbl[1] = '{1'b1, 29'h1000,    w_sparse, 32'h0FFF_FFF0, 0, -1, -1,  3, 0, 2};
    tbl[2] = '{1'b1, 29'h0_0123,  w_full,   32'hFFFF_FFFA, 0, -1, -1,  2, 0, 1};
    tbl[3] = '{1'b1, 29'h0_0456,  w_full,   32'hFFFF_FFFF, 0, -1, -1,  1, 0, 0};
    tbl[4] = '{1'b0, 29'h0_2000,  w_any,    32'h0,         3,  2, -1, 33, 1, 8};
    tbl[5] = '{1'b0, 29'h0_2001,  w_any,    32'h0,         0, -1, -1,  9, 0, 8};
    tbl[6] = '{1'b0, 29'h0_3000,  w_any,    32'h0,         0, -1,  0, 13, 1, 8};
    tbl[7] = '{1'b1, 29'h1FFF_FFFF, w_full, 32'h0,         1, -1, -1, 17, 0, 8};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cyc", 256'(bus.wb_cyc_o), 256'(0));
    chk("rst_stb", 256'(bus.wb_stb_o), 256'(0));
    chk("rst_adr", 256'(bus.wb_adr_o), 256'(0));
    chk("rst_we_sel_dat", 256'({bus.wb_we_o, bus.wb_sel_o, bus.wb_dat_o}), 256'(0));
    chk("rst_srdy_serr", 256'({bus.drac_srdy_o, bus.drac_serr_o}), 256'(0));
    chk("rst_srdat", bus.drac_srdat_o, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      slv_waits       = tbl[i].waits;
      slv_err_beat    = tbl[i].err_beat;
      slv_silent_beat = tbl[i].silent;
      run_txn($sformatf("tbl%0d", i), tbl[i].we, 1'b0, tbl[i].sa, tbl[i].wdat, tbl[i].msk,
              tbl[i].exp_lat, tbl[i].exp_serr, tbl[i].exp_nb);
      line = bus.drac_srdat_o;
      if (i == 0) chk("full_read_word5", 256'(line[191:160]), 256'(32'hA5));
      if (i == 4) chk("err_read_word2", 256'(line[95:64]), 256'(32'hFFFF_FFFF));
      if (i == 6) chk("tmo_read_word0", 256'(line[31:0]), 256'(32'hFFFF_FFFF));
    end

    // reset in the middle of beat 3 of a read
    slv_waits = 2; slv_err_beat = -1; slv_silent_beat = -1;
    @(negedge clk);
    bus.drac_sa_i  = 29'h0_0777;
    bus.drac_srd_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wb_stb_o && bus.wb_adr_o[2:0] == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid_reach_beat3", 256'(found), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_cyc", 256'(bus.wb_cyc_o), 256'(0));
    chk("rstmid_stb", 256'(bus.wb_stb_o), 256'(0));
    chk("rstmid_srdat", bus.drac_srdat_o, 256'(0));
    bus.drac_srd_i = 1'b0;
    exp_srdat = '0;
    @(negedge clk);
    rst_n = 1'b1;
    slv_waits = 0;
    run_txn("post_reset_read", 1'b0, 1'b0, 29'h0_0777, w_any, 32'h0, 9, 0, 8);

    // randomized requests
    for (int t = 0; t < 40; t++) begin
      logic we, both;
      logic [255:0] wd;
      we   = 1'($urandom_range(0, 1));
      both = we && ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 8; k++) begin
        wd[32*k +: 32] = $urandom;
        slv_mem[k]     = $urandom;
        case ($urandom_range(0, 3))
          0:       m[4*k +: 4] = 4'hF;
          1:       m[4*k +: 4] = 4'h0;
          default: m[4*k +: 4] = 4'($urandom);
        endcase
      end
      slv_waits       = $urandom_range(0, 3);
      slv_err_beat    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      slv_silent_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      slv_ack_on_err  = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", t), we, both, 29'($urandom), wd, m, -1, -1, -1);
    end

    chk("wb_outputs_stable", 256'(stab_viol), 256'(0));
    chk("cyc_equals_stb", 256'(cycstb_viol), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drac_wb_master.md
# drac_wb_master

Responder for the DRAC line-request interface that turns each 256-bit DRAC read or write into a burst of 32-bit Wishbone master cycles. It sits between a DRAC-side requester, such as the memory-side port of a bus adapter, and a 32-bit Wishbone slave fabric, for example on-chip RAM or a test memory model. Requests are latched, then issued as up to eight classic Wishbone beats under one `wb_cyc_o`, and completed with a single-cycle `drac_srdy_o`. Write beats whose four byte-mask bits are all set are skipped entirely.

## Interface
- `TIMEOUT`, default 255. Maximum number of cycles a beat may wait for `wb_ack_i` or `wb_err_i`. 0 disables the timeout.
- `clk_i` input 1: single clock, rising edge.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `drac_srd_i` input 1: line read request. Held until `drac_srdy_o`.
- `drac_swr_i` input 1: line write request. Held until `drac_srdy_o`.
- `drac_sa_i` input [33:5]: 32-byte line address.
- `drac_swdat_i` input 256: write data. Word k is bits [32k+31:32k].
- `drac_smsk_i` input 32: byte mask. 1 means the byte is not written. Bit 4k+b maps to byte b of word k.
- `drac_srdat_o` output 256: read line data.
- `drac_srdy_o` output 1: request complete, one-cycle pulse.
- `drac_serr_o` output 1: pulses with `drac_srdy_o` if any beat errored or timed out.
- `wb_adr_o` output [35:0]: 32-bit-word address.
- `wb_we_o` output 1: Wishbone write enable.
- `wb_sel_o` output 4: Wishbone byte selects.
- `wb_stb_o` output 1: Wishbone strobe.
- `wb_cyc_o` output 1: Wishbone cycle.
- `wb_dat_o` output 32: Wishbone write data.
- `wb_dat_i` input 32: Wishbone read data.
- `wb_ack_i` input 1: Wishbone beat acknowledge.
- `wb_err_i` input 1: Wishbone beat error.

## Operation
- States: IDLE, ISSUE, DONE.
- **Reset values.** Async reset forces IDLE. All outputs reset to 0, including `drac_srdat_o`, beat index, timeout counter and error flag. A request in flight at reset is dropped and the requester must re-issue it.
- **IDLE.** On a clock edge with `drac_srd_i` or `drac_swr_i` high, latch the address, write data, mask and direction. `drac_swr_i` wins if both are high.
  - Pending-beat vector: all ones for a read. For a write, bit k = ~&`drac_smsk_i`[4k+3:4k].
  - Clear the error flag.
  - If the pending vector is zero (fully masked write), go to DONE. Otherwise go to ISSUE with the beat index set to the lowest pending bit.
- **ISSUE.** `wb_cyc_o` and `wb_stb_o` are high in every ISSUE cycle.
  - `wb_adr_o` = {4'b0, latched sa[33:5], beat[2:0]}.
  - `wb_we_o` = latched direction.
  - `wb_dat_o` = latched word[beat].
  - `wb_sel_o` = 4'hF for reads; ~mask[4·beat+3:4·beat] for writes.
  - All Wishbone outputs are registered and stable while waiting.
- **Beat termination.** A beat ends on `wb_ack_i`, `wb_err_i`, or the timeout counter reaching `TIMEOUT`.
  - On a read, store `wb_dat_i` into word[beat] on ack. Store 32'hFFFFFFFF on error or timeout.
  - Error or timeout sets the error flag.
  - Clear the pending bit for the beat and move to the next lowest pending index. Skipped beats cost zero cycles.
  - If no beats remain, go to DONE and drop `wb_cyc_o`/`wb_stb_o` in the same edge.
- `wb_ack_i` and `wb_err_i` together: treat as error.
- **Timeout counter.** Resets at the start of each beat and counts each ISSUE cycle without termination.
- **DONE.** Exactly one cycle. `drac_srdy_o` = 1, and `drac_serr_o` = the error flag. Then return to IDLE.
- **`drac_srdat_o`.**
  - Read: updated per beat and fully valid in the `drac_srdy_o` cycle. It holds until the next read modifies it.
  - Write: leaves it unchanged.
- **Requester rules.** The requester keeps request and operands stable until `drac_srdy_o`, and may present a new request in the following cycle. Requests are not sampled in ISSUE or DONE.

## Timing
- Request high in IDLE cycle T.
  - First beat is driven in T+1.
  - With zero-wait acks, an n-beat burst acks in T+1..T+n, `drac_srdy_o` in T+n+1, IDLE in T+n+2.
- Full read with zero-wait slave: `drac_srdy_o` at T+9. Each slave wait state adds one cycle.
- Fully masked write: `drac_srdy_o` at T+1 and no Wishbone activity.
- Timeout: a beat with no response terminates after `TIMEOUT`+1 ISSUE cycles.
- Back-to-back requests: minimum of one IDLE cycle between `drac_srdy_o` and the next `wb_cyc_o`.

## Test plan
- **Full read.** `drac_srd_i`=1, sa=0x1000, zero-wait slave returning 0xA0+k for word k.
  - Expect eight beats with `wb_adr_o` 0x8000..0x8007 and sel F.
  - `drac_srdy_o` at T+9; srdat word k = 0xA0+k; `drac_serr_o`=0.
- **Sparse write.** smsk=0x0FFFFFF0, swdat word0=0x11111111, word7=0x77777777.
  - Expect exactly two beats: adr …0 with dat 0x11111111, and adr …7 with dat 0x77777777.
  - Both beats: sel F, we=1. `drac_srdy_o` at T+3.
- **Partial bytes and fully masked write.**
  - smsk=0xFFFFFFFA: one beat with sel=4'b0101.
  - smsk=0xFFFFFFFF: `drac_srdy_o` at T+1, `wb_cyc_o` never rises.
- **Wait states and error.** Slave inserts 3 wait states per beat on a read and asserts `wb_err_i` on beat 2.
  - Expect `drac_srdy_o` at T+33 and srdat word2 = 0xFFFFFFFF.
  - `drac_serr_o`=1 with srdy. Next clean request gives `drac_serr_o`=0.
- **Timeout.** `TIMEOUT`=4, slave never responds on beat 0 of a read.
  - Beat 0 terminates after 5 cycles and the remaining beats proceed normally.
  - `drac_serr_o`=1 with srdy.
- **Reset mid-burst.** Assert `rst_n_i` low during beat 3 of a read.
  - `wb_cyc_o`, `wb_stb_o` and `drac_srdat_o` go to 0 immediately.
  - After release, a new read completes normally.
